mic_frame_buffer: RTL and testbench
===================================

# mic_frame_buffer

Ping-pong frame buffer between the microphone sample decoder and the FFT core's AXI-Stream data input. It collects signed PCM samples into frames of FRAME_LEN, then streams each completed frame as a complex word (imag = 0) with TLAST on the final sample. Capture into one bank overlaps draining of the other. Overruns are counted, not stalled.

## Interface
- DATA_WIDTH, 16, signed PCM sample width; legal range 8..16.
- FRAME_LEN, 512, samples per frame; power of two, 16..4096.
- CNT_WIDTH, 16, width of the overflow counter.

- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- capture_en  in  1  1 = accept samples; 0 = ignore sample_valid.
- sample_in  in  DATA_WIDTH  signed PCM sample.
- sample_valid  in  1  one-cycle strobe, sample_in valid; no backpressure.
- m_axis_tdata  out  32  {16'h0000 imag, sign-extended real in [15:0]}.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready from the FFT core.
- m_axis_tlast  out  1  high on sample index FRAME_LEN-1.
- frame_done  out  1  one-cycle pulse when the TLAST beat handshakes.
- overflow_cnt  out  CNT_WIDTH  saturating count of dropped samples.
- bank_full  out  2  per-bank full flag, for status readback.

## Operation
- Two banks of FRAME_LEN x DATA_WIDTH, inferred as block RAM with 1-cycle synchronous read. Each bank is in one state: EMPTY, FILLING, FULL or DRAINING.
- Write side:
  - Holds wr_bank and wr_idx (log2 FRAME_LEN bits).
  - An accepted sample requires capture_en=1, sample_valid=1, and wr_bank EMPTY or FILLING. It writes at wr_idx and increments wr_idx.
  - At wr_idx = FRAME_LEN-1, wr_idx wraps to 0, the bank becomes FULL, and wr_bank toggles.
  - If the target bank is FULL or DRAINING, the sample is dropped and overflow_cnt increments. The counter saturates at all-ones.
  - capture_en=0 drops samples silently: no count, wr_idx held. The partial frame resumes when capture_en returns to 1.
- Read FSM states and transitions:
  - IDLE: on rd_bank FULL, go to PRIME and mark the bank DRAINING.
  - PRIME: issue RAM read of index 0, go to STREAM.
  - STREAM: present words in order. Prefetch with a 2-entry skid so that continuous tready yields one beat per cycle. After the TLAST handshake, mark the bank EMPTY, toggle rd_bank, pulse frame_done, and go to IDLE.
- Banks drain strictly in fill order, starting at bank 0 after reset.
- tdata[15:0] is sample_in sign-extended to 16 bits; tdata[31:16] = 0.
- AXI-Stream rules:
  - tvalid never deasserts without a handshake.
  - tdata and tlast are stable while tvalid=1 and tready=0.
  - tvalid does not depend combinationally on tready.
- Simultaneous events:
  - A write-side FULL transition and the read FSM release of the other bank in the same cycle are both honoured.
  - A sample arriving in the release cycle of its target bank is dropped (counted). The state update takes effect next cycle.
- bank_full[b] = 1 while bank b is FULL or DRAINING.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0, overflow_cnt=0, bank_full=2'b00.
  - FSM in IDLE; wr_bank=rd_bank=0; wr_idx=0; both banks EMPTY.
  - Reset mid-frame or mid-stream discards all buffered data. tvalid drops the cycle after ARESET is sampled high.
- Latency: the final sample of a frame is written at edge t. Then bank_full updates at t+1, and m_axis_tvalid rises at t+3 with index 0.
- Throughput: one beat per cycle while tready=1. An uninterrupted frame spans exactly FRAME_LEN cycles of tvalid.
- Bank turnaround: after the TLAST handshake at edge u, tvalid is low at u+1 at minimum. If the other bank is already FULL, tvalid reasserts at u+3.
- frame_done is high exactly the cycle after the TLAST handshake edge.

## Test plan
- Single frame, FRAME_LEN=16, tready=1: capture samples 0..15.
  - Expect 16 beats with tdata = 0x00000000..0x0000000F.
  - Expect tlast only on the 16th beat, one frame_done pulse, and overflow_cnt=0.
- Sign extension, DATA_WIDTH=12: sample 12'h800 -> tdata = 0x0000F800; sample 12'h7FF -> tdata = 0x000007FF.
- Backpressure: toggle tready pseudo-randomly over 3 consecutive frames.
  - Expect all 48 words in order, with tdata and tlast held stable while stalled.
  - Expect no gaps inside a frame when tready=1.
- Overflow: hold tready=0 and feed 40 samples at FRAME_LEN=16.
  - Expect bank_full=2'b11 and overflow_cnt=8.
  - Release tready: the output is samples 0..31, and overflow_cnt stays 8.
  - Saturation check with CNT_WIDTH=4: 20 drops -> overflow_cnt=15.
- capture_en gating: write 5 samples, deassert for 10 strobes, reassert and write 11 more.
  - Expect one frame containing only the 16 accepted samples, and overflow_cnt=0.
- Reset mid-stream: assert ARESET during beat 7 of a frame.
  - Expect tvalid=0 the next cycle and bank_full=0.
  - A fresh frame afterwards starts from the new samples at index 0.

Source files
------------

// File: rtl/mic_frame_buffer.sv
// ============================================================================
//  Module   : mic_frame_buffer
//  Purpose  : Ping-pong frame buffer between the microphone sample decoder
//             and the FFT core's AXI-Stream input. Signed PCM samples are
//             collected into frames of FRAME_LEN in one bank. Meanwhile, the
//             other bank is streamed out as complex words (imag = 0), with
//             TLAST on the final sample. When both banks are occupied, new
//             samples are dropped and counted instead of stalling the input.
//  Ports    : ACLK, ARESET     - clock, synchronous active-high reset
//             capture_en       - 1 = accept samples, 0 = ignore strobes
//             sample_in        - signed PCM sample (DATA_WIDTH bits)
//             sample_valid     - one-cycle sample strobe, no backpressure
//             m_axis_tdata     - {16'h0000, sign-extended sample}
//             m_axis_tvalid    - AXI-Stream valid
//             m_axis_tready    - AXI-Stream ready from the FFT core
//             m_axis_tlast     - high on sample index FRAME_LEN-1
//             frame_done       - one-cycle pulse after the TLAST handshake
//             overflow_cnt     - saturating count of dropped samples
//             bank_full        - per-bank FULL/DRAINING status
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mic_frame_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 512,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  capture_en,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  overflow_cnt,
  output logic [1:0]            bank_full
);

  localparam int              c_AW       = $clog2(FRAME_LEN);
  localparam logic [c_AW-1:0] c_LAST_IDX = c_AW'(FRAME_LEN - 1);

  // Bank occupancy encoding
  localparam logic [1:0] c_EMPTY    = 2'd0;
  localparam logic [1:0] c_FILLING  = 2'd1;
  localparam logic [1:0] c_FULL     = 2'd2;
  localparam logic [1:0] c_DRAINING = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2
  } rd_state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]            r_bank_st [2];
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [c_AW-1:0]       r_wr_idx;
  logic [CNT_WIDTH-1:0]  r_ovf_cnt;
  logic [1:0]            r_bank_full;
  logic                  r_frame_done;

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic                  w_claim;
  logic                  w_release;
  logic                  w_rd_en;
  logic                  w_issue;

  // The extra MSB marks "all FRAME_LEN reads issued".
  logic [c_AW:0]         r_rd_addr;
  logic                  r_ram_vld;
  logic                  r_ram_last;
  logic [1:0][DATA_WIDTH-1:0] w_dout;
  logic [15:0]           w_ext;

  // Two-entry output skid: head entry drives the AXI-Stream outputs.
  logic [15:0]           r_fifo_data [2];
  logic                  r_fifo_last [2];
  logic                  r_fifo_wptr;
  logic                  r_fifo_rptr;
  logic [1:0]            r_fifo_cnt;
  logic                  w_pop;
  logic                  w_head_last;
  logic [2:0]            w_inflight;

  logic                  w_strobe;
  logic                  w_wr_open;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_wr_wrap;

  // --------------------------------------------------------------------------
  // Write side
  // --------------------------------------------------------------------------
  assign w_strobe  = capture_en & sample_valid;
  assign w_wr_open = (r_bank_st[r_wr_bank] == c_EMPTY) ||
                     (r_bank_st[r_wr_bank] == c_FILLING);
  assign w_accept  = w_strobe & w_wr_open;
  assign w_drop    = w_strobe & ~w_wr_open;
  assign w_wr_wrap = w_accept & (r_wr_idx == c_LAST_IDX);

  // --------------------------------------------------------------------------
  // Sample banks: simple dual-port RAM, one-cycle registered read
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [FRAME_LEN];
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge ACLK) begin
      if (w_accept && (r_wr_bank == 1'(b))) begin
        r_mem[r_wr_idx] <= sample_in;
      end
      if (w_rd_en && (r_rd_bank == 1'(b))) begin
        r_dout <= r_mem[r_rd_addr[c_AW-1:0]];
      end
    end

    assign w_dout[b] = r_dout;
  end

  // rd_bank only toggles once the frame has fully left the skid,
  // so no read is ever in flight across the toggle.
  assign w_ext = 16'($signed(w_dout[r_rd_bank]));

  // --------------------------------------------------------------------------
  // Bank bookkeeping, write pointer and overflow counter
  // --------------------------------------------------------------------------
  // The write side only touches EMPTY/FILLING banks, and the read side only
  // touches FULL/DRAINING banks. Both updates can therefore land in the same
  // cycle without conflict.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_bank_st[0] <= c_EMPTY;
      r_bank_st[1] <= c_EMPTY;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_idx     <= '0;
      r_ovf_cnt    <= '0;
      r_bank_full  <= 2'b00;
      r_frame_done <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_accept && (r_wr_bank == 1'(b))) begin
          r_bank_st[b] <= w_wr_wrap ? c_FULL : c_FILLING;
        end else if (w_claim && (r_rd_bank == 1'(b))) begin
          r_bank_st[b] <= c_DRAINING;
        end else if (w_release && (r_rd_bank == 1'(b))) begin
          r_bank_st[b] <= c_EMPTY;
        end
        r_bank_full[b] <= (r_bank_st[b] == c_FULL) || (r_bank_st[b] == c_DRAINING);
      end

      // FRAME_LEN is a power of two, so the index wraps naturally.
      if (w_accept) begin
        r_wr_idx <= r_wr_idx + 1'b1;
        if (w_wr_wrap) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end

      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
      end

      if (w_drop && !(&r_ovf_cnt)) begin
        r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end

      r_frame_done <= w_release;
    end
  end

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  assign m_axis_tvalid = (r_fifo_cnt != 2'd0);
  assign w_head_last   = r_fifo_last[r_fifo_rptr];
  assign w_pop         = m_axis_tvalid & m_axis_tready;

  // A read issued now lands in the skid one cycle later. Allow it only if the
  // skid cannot exceed two entries, even if nothing pops next cycle.
  assign w_inflight = 3'(r_fifo_cnt) + 3'(r_ram_vld);
  assign w_issue    = ~r_rd_addr[c_AW] && ((w_inflight - 3'(w_pop)) <= 3'd1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_claim     = 1'b0;
    w_release   = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_bank_st[r_rd_bank] == c_FULL) begin
          w_claim     = 1'b1;
          w_state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        w_rd_en     = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_rd_en = w_issue;
        if (w_pop && w_head_last) begin
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read address, RAM-valid tracking and output skid
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_addr      <= '0;
      r_ram_vld      <= 1'b0;
      r_ram_last     <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_fifo_wptr    <= 1'b0;
      r_fifo_rptr    <= 1'b0;
      r_fifo_cnt     <= 2'd0;
    end else begin
      if (r_state == S_IDLE) begin
        r_rd_addr <= '0;
      end else if (w_rd_en) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
      r_ram_vld  <= w_rd_en;
      r_ram_last <= w_rd_en && (r_rd_addr[c_AW-1:0] == c_LAST_IDX);

      if (r_ram_vld) begin
        r_fifo_data[r_fifo_wptr] <= w_ext;
        r_fifo_last[r_fifo_wptr] <= r_ram_last;
        r_fifo_wptr              <= ~r_fifo_wptr;
      end
      if (w_pop) begin
        r_fifo_rptr <= ~r_fifo_rptr;
      end
      r_fifo_cnt <= r_fifo_cnt + 2'(r_ram_vld) - 2'(w_pop);
    end
  end

  assign m_axis_tdata = {16'h0000, r_fifo_data[r_fifo_rptr]};
  assign m_axis_tlast = m_axis_tvalid & w_head_last;
  assign frame_done   = r_frame_done;
  assign overflow_cnt = r_ovf_cnt;
  assign bank_full    = r_bank_full;

endmodule

`default_nettype wire

// File: tb/tb_mic_frame_buffer.sv
// ============================================================================
//  Module   : tb_mic_frame_buffer
//  Purpose  : Directed self-checking bench for mic_frame_buffer.
//             It uses a 12-bit sample width, 16-sample frames and a 4-bit
//             overflow counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mic_frame_buffer;

  localparam int DW = 12;
  localparam int FL = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          capture_en;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic [31:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          frame_done;
  logic [CW-1:0] ovf;
  logic [1:0]    bank_full;

  always #5 clk = ~clk;

  mic_frame_buffer #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .CNT_WIDTH (CW)
  ) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .capture_en   (capture_en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .frame_done   (frame_done),
    .overflow_cnt (ovf),
    .bank_full    (bank_full)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode = 0;   // 0: tready low, 1: tready high, 2: random
  int          vcyc = 0;
  int          fd_cnt = 0;
  logic        mid_frame = 1'b0;
  logic [31:0] got_q [$];
  logic        got_last_q [$];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [DW-1:0] s);
    return {16'h0000, {(16-DW){s[DW-1]}}, s};
  endfunction

  // One clock cycle. It is called just after an active edge, with inputs set.
  task automatic tick();
    logic        hs;
    logic        stall;
    logic        in_rst;
    logic [31:0] pdata;
    logic        plast;
    if (rdy_mode == 2) tready = ($urandom_range(0, 3) != 0);
    else               tready = (rdy_mode == 1);
    in_rst = rst;
    if (mid_frame && !in_rst) chk("gap", tvalid, 1);
    hs    = tvalid && tready && !in_rst;
    stall = tvalid && !tready && !in_rst;
    pdata = tdata;
    plast = tlast;
    if (tvalid && !in_rst) vcyc++;
    if (hs) begin
      got_q.push_back(tdata);
      got_last_q.push_back(tlast);
      mid_frame = !tlast;
    end
    @(posedge clk);
    #1;
    if (in_rst) mid_frame = 1'b0;
    if (frame_done) fd_cnt++;
    chk("frame_done", frame_done, hs && plast);
    if (stall) begin
      chk("hold_valid", tvalid, 1);
      chk("hold_data", tdata, pdata);
      chk("hold_last", tlast, plast);
    end
  endtask

  task automatic send(input logic [DW-1:0] s, input logic en);
    capture_en   = en;
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    capture_en   = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got_q.size() < n) chk("timeout_beats", got_q.size(), n);
  endtask

  task automatic clear_q();
    got_q.delete();
    got_last_q.delete();
    exp_q.delete();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, "_data"}, got_q[i], exp_word(exp_q[i]));
      chk({tag, "_last"}, got_last_q[i], (i % FL) == FL - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; capture_en = 1'b1; sample_in = '0; sample_valid = 1'b0; tready = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_bank_full", bank_full, 2'b00);
    rst = 1'b0;

    // Single frame with latency and throughput checks
    clear_q(); rdy_mode = 1; vcyc = 0; fd_cnt = 0;
    for (int i = 0; i < FL; i++) begin
      send(DW'(i), 1'b1);
      exp_q.push_back(DW'(i));
    end
    chk("lat_t0_valid", tvalid, 0);
    chk("lat_t0_full", bank_full, 2'b00);
    tick();
    chk("lat_t1_full", bank_full, 2'b01);
    chk("lat_t1_valid", tvalid, 0);
    tick();
    chk("lat_t2_valid", tvalid, 0);
    tick();
    chk("lat_t3_valid", tvalid, 1);
    chk("lat_t3_data", tdata, 32'h0);
    run_until(FL, 100);
    repeat (4) tick();
    check_stream("single");
    chk("single_vcyc", vcyc, FL);
    chk("single_fd", fd_cnt, 1);
    chk("single_ovf", ovf, 0);
    chk("single_full_after", bank_full, 2'b00);

    // Sign extension
    clear_q();
    for (int i = 0; i < FL; i++) begin
      logic [DW-1:0] s;
      s = (i == 0) ? 12'h800 : (i == 1) ? 12'h7FF : (i == 2) ? 12'hFFF : DW'(i);
      send(s, 1'b1);
      exp_q.push_back(s);
    end
    run_until(FL, 100);
    repeat (4) tick();
    check_stream("sext");
    chk("sext_neg", got_q[0], 32'h0000F800);
    chk("sext_pos", got_q[1], 32'h000007FF);
    chk("sext_m1", got_q[2], 32'h0000FFFF);

    // Backpressure across three frames
    clear_q(); rdy_mode = 2; fd_cnt = 0;
    for (int i = 0; i < 3 * FL; i++) begin
      send(DW'(i * 37 + 5), 1'b1);
      exp_q.push_back(DW'(i * 37 + 5));
      repeat (2) tick();
    end
    run_until(3 * FL, 1000);
    repeat (4) tick();
    check_stream("bp");
    chk("bp_fd", fd_cnt, 3);
    chk("bp_ovf", ovf, 0);

    // Overflow: both banks fill, 8 samples dropped
    clear_q(); rdy_mode = 0; fd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      send(DW'(i), 1'b1);
      if (i < 32) exp_q.push_back(DW'(i));
    end
    repeat (4) tick();
    chk("ovf_full", bank_full, 2'b11);
    chk("ovf_cnt", ovf, 8);
    rdy_mode = 1;
    run_until(32, 200);
    repeat (4) tick();
    check_stream("ovf");
    chk("ovf_cnt_after", ovf, 8);
    chk("ovf_fd", fd_cnt, 2);

    // Saturation of the 4-bit counter
    do_reset();
    chk("sat_rst_ovf", ovf, 0);
    clear_q(); rdy_mode = 0;
    for (int i = 0; i < 52; i++) send(DW'(i), 1'b1);
    repeat (2) tick();
    chk("sat_ovf", ovf, 15);
    chk("sat_full", bank_full, 2'b11);

    // capture_en gating
    do_reset();
    clear_q(); rdy_mode = 1; fd_cnt = 0;
    for (int i = 0; i < 5; i++)  begin send(DW'(100 + i), 1'b1); exp_q.push_back(DW'(100 + i)); end
    for (int i = 0; i < 10; i++) send(DW'(200 + i), 1'b0);
    for (int i = 5; i < 16; i++) begin send(DW'(100 + i), 1'b1); exp_q.push_back(DW'(100 + i)); end
    run_until(FL, 100);
    repeat (4) tick();
    check_stream("gate");
    chk("gate_ovf", ovf, 0);
    chk("gate_fd", fd_cnt, 1);

    // Reset during beat 7 of a frame
    clear_q(); rdy_mode = 1;
    for (int i = 0; i < FL; i++) send(DW'(300 + i), 1'b1);
    run_until(7, 100);
    chk("mrst_pre_valid", tvalid, 1);
    do_reset();
    chk("mrst_valid", tvalid, 0);
    chk("mrst_full", bank_full, 2'b00);
    clear_q();
    for (int i = 0; i < FL; i++) begin
      send(DW'(400 + i), 1'b1);
      exp_q.push_back(DW'(400 + i));
    end
    run_until(FL, 100);
    repeat (4) tick();
    check_stream("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
